// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and opcode encoding.
package alu_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_SLTU = 3'd7
    } opcode_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath. Bit WIDTH of the result carries the ADD carry
// or SUB borrow; all other operations are zero-extended.
// Build option: define ALU_SLTU_EN to implement SLTU on opcode 7; otherwise
// opcode 7 returns zero and no comparator is built.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH:0]      res_c
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Opcode decode; the WIDTH+1-bit subtract leaves the borrow in the top bit.
    always_comb begin
        res_c = '0;
        case (opcode_e'(opcode))
            OP_ADD:  res_c = a_ext + b_ext;
            OP_SUB:  res_c = a_ext - b_ext;
            OP_AND:  res_c = a_ext & b_ext;
            OP_OR:   res_c = a_ext | b_ext;
            OP_XOR:  res_c = a_ext ^ b_ext;
            OP_NOR:  res_c = {1'b0, ~(a | b)};
            OP_XNOR: res_c = {1'b0, ~(a ^ b)};
`ifdef ALU_SLTU_EN
            OP_SLTU: res_c = (WIDTH+1)'(a < b);
`else
            OP_SLTU: res_c = '0;
`endif
            default: res_c = '0;
        endcase
    end

endmodule : alu_core

// File: rtl/alu_32bit.sv
// Registered ALU: one-cycle latency, new operation every cycle; en=0 clears
// the result. Build option ALU_SLTU_EN (see alu_core) enables SLTU.
module alu_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH:0]      out
);

    logic [WIDTH:0] res_c;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .res_c  (res_c)
    );

    // Output register: async clear, load result when enabled, else clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (en) begin
            out <= res_c;
        end else begin
            out <= '0;
        end
    end

endmodule : alu_32bit

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed vectors, reset scenarios and
// randomized operations against an arithmetic reference model.
module tb_alu_32bit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] out;

    int total;
    int bad;

    alu_32bit #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%09h exp=0x%09h", tag, got, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on 64-bit values.
    function automatic logic [32:0] ref_alu(input int unsigned op, input logic [31:0] a32, input logic [31:0] b32);
        longint unsigned x;
        longint unsigned y;
        longint unsigned r;
        x = longint'(a32);
        y = longint'(b32);
        r = 0;
        case (op)
            0: r = x + y;
            1: r = (x < y) ? (64'h1_0000_0000 + (x + 64'h1_0000_0000 - y)) : (x - y);
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 64'hffff_ffff - (x | y);
            6: r = 64'hffff_ffff - (x ^ y);
`ifdef ALU_SLTU_EN
            7: r = (x < y) ? 1 : 0;
`else
            7: r = 0;
`endif
            default: r = 0;
        endcase
        return 33'(r);
    endfunction

    // Drive one operation away from the edge, then check one cycle later.
    task automatic do_op(input string tag, input logic e, input logic [2:0] op,
                         input logic [31:0] av, input logic [31:0] bv, input logic [32:0] exp);
        @(negedge clk);
        en = e; opcode = op; a = av; b = bv;
        @(posedge clk);
        #1;
        check_eq(tag, out, exp);
    endtask

    initial begin
        logic [32:0] sltu_exp;
        logic [32:0] hold;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        en = 1'b1;
        opcode = 3'd0;
        a = 32'hffff_ffff;
        b = 32'hffff_ffff;

`ifdef ALU_SLTU_EN
        sltu_exp = 33'h0_0000_0001;
`else
        sltu_exp = 33'h0;
`endif

        // Reset state, including across clock edges with en=1.
        #1;
        check_eq("reset_initial", out, 33'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", out, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_op("add_basic", 1'b1, 3'd0, 32'h0000_abcd, 32'h0000_def2, 33'h0_0001_8abf);
        do_op("sub_borrow", 1'b1, 3'd1, 32'ha, 32'hd, 33'h1_ffff_fffd);
        do_op("and", 1'b1, 3'd2, 32'h00de_fca1, 32'h023b_e00a, 33'h0_001a_e000);
        do_op("or", 1'b1, 3'd3, 32'h0dec_a032, 32'h00ab_77ca, 33'h0_0def_f7fa);
        do_op("xor", 1'b1, 3'd4, 32'h0aaa_702b, 32'h0bb0_0afe, 33'h0_011a_7ad5);
        do_op("nor", 1'b1, 3'd5, 32'h0000_ffff, 32'hf000_0000, 33'h0_0fff_0000);
        do_op("xnor", 1'b1, 3'd6, 32'hffff_0000, 32'hff00_ff00, 33'h0_ff00_00ff);
        do_op("sltu_lt", 1'b1, 3'd7, 32'h5, 32'h9, sltu_exp);
        do_op("sltu_ge", 1'b1, 3'd7, 32'h9, 32'h5, 33'h0);
        do_op("sub_equal", 1'b1, 3'd1, 32'h1234_5678, 32'h1234_5678, 33'h0);
        do_op("sub_nobrw", 1'b1, 3'd1, 32'hd, 32'ha, 33'h0_0000_0003);
        do_op("add_wrap", 1'b1, 3'd0, 32'hffff_ffff, 32'h1, 33'h1_0000_0000);
        do_op("en_low_clear", 1'b0, 3'd6, 32'haedf_bcac, 32'haedf_bcac, 33'h0);

        // Output must not follow inputs between edges.
        do_op("hold_load", 1'b1, 3'd4, 32'hf0f0_f0f0, 32'h0f0f_0f0f, 33'h0_ffff_ffff);
        @(negedge clk);
        opcode = 3'd2; a = 32'h0; b = 32'h0; en = 1'b0;
        #1;
        check_eq("no_comb_path", out, 33'h0_ffff_ffff);

        // Asynchronous mid-stream reset.
        do_op("pre_reset", 1'b1, 3'd0, 32'h8000_0000, 32'h8000_0001, 33'h1_0000_0001);
        @(negedge clk);
        opcode = 3'd3; a = 32'hdead_beef; b = 32'h1; en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", out, 33'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold_edge", out, 33'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset_load", 1'b1, 3'd3, 32'hdead_beef, 32'h1, 33'h0_dead_beef);

        // Randomized operations, biased to hit equal operands and en=0.
        for (int i = 0; i < 300; i++) begin
            logic        e;
            logic [2:0]  op;
            logic [31:0] av;
            logic [31:0] bv;
            e  = ($urandom_range(0, 7) != 0);
            op = 3'($urandom_range(0, 7));
            av = $urandom;
            bv = ($urandom_range(0, 9) == 0) ? av : $urandom;
            if ($urandom_range(0, 9) == 0) av = 32'hffff_ffff;
            hold = e ? ref_alu(int'(op), av, bv) : 33'h0;
            do_op("random", e, op, av, bv, hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_32bit
